// File: rtl/fifo_read_packer.sv
// fifo_read_packer: packs RATIO narrow beats from the async FIFO read port
// into one wide word, LSB lane first. A flush emits a partial word with a
// lane-keep mask. Single read-domain clock, synchronous active-low reset.
module fifo_read_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [RATIO*DATA_WIDTH-1:0]   out_data,
  output logic [RATIO-1:0]              out_keep,
  input  logic                          out_ready
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OW = RATIO * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_PEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     acc_data_q, acc_data_d;
  logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
  logic [OW-1:0]     out_data_q, out_data_d;
  logic [RATIO-1:0]  out_keep_q, out_keep_d;
  logic              out_valid_q, out_valid_d;

  logic              slot_free;
  logic              accept;
  logic              full_beat;
  logic              flush_req;
  logic [CW:0]       eff_cnt;
  logic [OW-1:0]     merged;
  logic [RATIO-1:0]  partial_keep;

  // Handshake qualification: a partial word is wanted while pending, or on a
  // fresh flush that neither coincides with a completing beat nor finds the
  // accumulator empty (counting a beat accepted on the same edge).
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    accept    = in_valid && in_ready;
    full_beat = accept && (acc_cnt_q == LAST_LANE);
    eff_cnt   = {1'b0, acc_cnt_q} + {{CW{1'b0}}, accept};
    flush_req = (state_q == FLUSH_PEND) ||
                (flush && !full_beat && (eff_cnt != '0));
  end

  // Accumulator contents with this cycle's beat dropped into its lane, plus
  // the keep mask a partial word would carry.
  always_comb begin
    merged       = acc_data_q;
    partial_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (accept && (acc_cnt_q == CW'(k))) begin
        merged[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
      partial_keep[k] = ((CW+1)'(k) < eff_cnt);
    end
  end

  // Flush FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush FSM: next state. A flush that cannot load immediately waits in
  // FLUSH_PEND until the output slot frees.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:       if (flush_req && !slot_free) state_d = FLUSH_PEND;
      FLUSH_PEND: if (slot_free)               state_d = FILL;
      default:                                 state_d = FILL;
    endcase
  end

  // Flush FSM: outputs. Input is blocked while a flush is pending, and on the
  // last lane while the output register cannot take a new word.
  always_comb begin
    in_ready = (state_q == FILL) && ((acc_cnt_q != LAST_LANE) || slot_free);
  end

  // Datapath next state: load a full or partial word, otherwise accumulate.
  always_comb begin
    acc_data_d  = acc_data_q;
    acc_cnt_d   = acc_cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q && !out_ready;
    if (full_beat) begin
      out_data_d  = merged;
      out_keep_d  = '1;
      out_valid_d = 1'b1;
      acc_data_d  = '0;
      acc_cnt_d   = '0;
    end else if (flush_req && slot_free) begin
      out_data_d  = merged;
      out_keep_d  = partial_keep;
      out_valid_d = 1'b1;
      acc_data_d  = '0;
      acc_cnt_d   = '0;
    end else if (accept) begin
      acc_data_d  = merged;
      acc_cnt_d   = acc_cnt_q + CW'(1);
    end
  end

  // Datapath registers; reset discards any accepted-but-unemitted beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_data_q  <= '0;
      acc_cnt_q   <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_cnt_q   <= acc_cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Testbench for fifo_read_packer: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_fifo_read_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [R-1:0]  out_keep;
  logic          out_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] acc[$];
  bit            pend  = 0;
  bit            known = 0;
  logic          m_ov  = 1'b0;
  logic [OW-1:0] m_od  = '0;
  logic [R-1:0]  m_ok  = '0;

  always #5 clk = ~clk;

  fifo_read_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_acc();
    logic [OW-1:0] w;
    w = '0;
    foreach (acc[i]) w[i*DW +: DW] = acc[i];
    return w;
  endfunction

  // One clock: drive at the falling edge, check outputs from the previous
  // rising edge plus the combinational ready, then advance the model.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic f, input logic o);
    bit ir, sf, loaded;
    @(negedge clk);
    rst_n = r; in_valid = v; in_data = d; flush = f; out_ready = o;
    #1;
    ir = !pend && ((acc.size() != R - 1) || !m_ov || o);
    if (known) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_data",  64'(out_data),  64'(m_od));
      chk("out_keep",  64'(out_keep),  64'(m_ok));
      if (r) chk("in_ready", 64'(in_ready), 64'(ir));
    end
    if (!r) begin
      acc.delete(); pend = 0; m_ov = 1'b0; m_od = '0; m_ok = '0; known = 1;
    end else if (known) begin
      sf = !m_ov || o;
      loaded = 0;
      if (v && ir) acc.push_back(d);
      if (acc.size() == R) begin
        m_od = pack_acc(); m_ok = '1; loaded = 1; acc.delete();
      end else if ((pend || f) && acc.size() != 0) begin
        if (sf) begin
          m_od = pack_acc(); m_ok = R'((1 << acc.size()) - 1);
          loaded = 1; acc.delete(); pend = 0;
        end else begin
          pend = 1;
        end
      end
      m_ov = loaded ? 1'b1 : (m_ov && !o);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic o);
    step(1'b1, 1'b1, d, 1'b0, o);
  endtask

  task automatic idle(input logic o);
    step(1'b1, 1'b0, '0, 1'b0, o);
  endtask

  initial begin
    // Reset held two cycles with in_valid high
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    idle(1'b1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_keep",  64'(out_keep),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // Streaming
    beat(8'h11, 1'b1); beat(8'h22, 1'b1); beat(8'h33, 1'b1); beat(8'h44, 1'b1);
    beat(8'h55, 1'b1);
    chk("stream_w0_valid", 64'(out_valid), 64'd1);
    chk("stream_w0_data",  64'(out_data),  64'h44332211);
    chk("stream_w0_keep",  64'(out_keep),  64'hF);
    beat(8'h66, 1'b1); beat(8'h77, 1'b1); beat(8'h88, 1'b1);
    idle(1'b1);
    chk("stream_w1_valid", 64'(out_valid), 64'd1);
    chk("stream_w1_data",  64'(out_data),  64'h88776655);

    // Backpressure
    beat(8'h11, 1'b1); beat(8'h22, 1'b1); beat(8'h33, 1'b1); beat(8'h44, 1'b1);
    beat(8'h55, 1'b0); beat(8'h66, 1'b0); beat(8'h77, 1'b0);
    beat(8'h88, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_data_stable",  64'(out_data), 64'h44332211);
    beat(8'h88, 1'b1);
    chk("bp_in_ready_high", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("bp_w1_data", 64'(out_data), 64'h88776655);

    // Partial flush with no beat
    beat(8'hA1, 1'b1); beat(8'hB2, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    chk("pflush_data", 64'(out_data), 64'h0000B2A1);
    chk("pflush_keep", 64'(out_keep), 64'h3);

    // Flush together with the 3rd beat
    beat(8'hA1, 1'b1); beat(8'hB2, 1'b1);
    step(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
    idle(1'b1);
    chk("fbeat3_data", 64'(out_data), 64'h00C3B2A1);
    chk("fbeat3_keep", 64'(out_keep), 64'h7);

    // Flush together with the completing beat
    beat(8'hA1, 1'b1); beat(8'hB2, 1'b1); beat(8'hC3, 1'b1);
    step(1'b1, 1'b1, 8'hD4, 1'b1, 1'b1);
    idle(1'b1);
    chk("fbeat4_data", 64'(out_data), 64'hD4C3B2A1);
    chk("fbeat4_keep", 64'(out_keep), 64'hF);
    idle(1'b1);
    chk("fbeat4_no_extra", 64'(out_valid), 64'd0);

    // Stalled flush with one lane
    beat(8'h11, 1'b1); beat(8'h22, 1'b1); beat(8'h33, 1'b1); beat(8'h44, 1'b1);
    beat(8'hE5, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    beat(8'hF6, 1'b0);
    chk("sflush_ready_low0", 64'(in_ready), 64'd0);
    beat(8'hF6, 1'b1);
    chk("sflush_ready_low1", 64'(in_ready), 64'd0);
    idle(1'b1);
    chk("sflush_valid", 64'(out_valid), 64'd1);
    chk("sflush_data",  64'(out_data),  64'h000000E5);
    chk("sflush_keep",  64'(out_keep),  64'h1);

    // Mid-word reset drops pending lanes
    beat(8'h01, 1'b1); beat(8'h02, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, (i == 1), 1'b1);
      chk("mreset_no_word", 64'(out_valid), 64'd0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 3) != 0),
           DW'($urandom),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0));
    end
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
